// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - buffered 8N1 UART transmitter with doorbell-fed FIFO
module uart_tx_queue #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               data_in,
    input  logic                     doorbell,
    input  logic                     ovf_clr,
    output logic                     tx,
    output logic                     busy,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    // Clocks per bit; the baud counter runs 0..DIV-1 within each bit.
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int BCW = $clog2(DIV);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Storage and registered state
    logic [7:0]     r_mem [DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic           r_overflow;
    state_t         r_state;
    logic           r_tx;
    logic [7:0]     r_shift;
    logic [BCW-1:0] r_baud;
    logic [2:0]     r_bit;

    // Next-state values from the serializer process
    state_t         w_state_nxt;
    logic           w_tx_nxt;
    logic [7:0]     w_shift_nxt;
    logic [BCW-1:0] w_baud_nxt;
    logic [2:0]     w_bit_nxt;
    logic           w_pop;

    // FIFO status, derived only from the registered pointers
    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_drop;
    logic           w_baud_last;
    logic [7:0]     w_head;

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head      = r_mem[r_rptr[AW-1:0]];
    assign w_baud_last = (r_baud == BAUD_LAST);

    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // still accepted in that case.
    assign w_push = doorbell && (!w_full || w_pop);
    assign w_drop = doorbell && w_full && !w_pop;

    // Serializer next-state and datapath: one frame = start, 8 data LSB first, stop
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shift[1];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame with no idle gap
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Serializer registers; tx comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // FIFO pointers and sticky overflow flag (a set beats a same-edge clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= data_in;
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE);
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_wptr - r_rptr;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - randomized scoreboard bench for uart_tx_queue
module tb_uart_tx_queue;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 8;
    localparam int DIV      = 10;
    localparam int FRAME    = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       doorbell = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx;
    logic       busy;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_queue #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .doorbell (doorbell),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: FIFO as a queue, frames as (pop edge, byte) pairs
    logic [7:0] mq[$];
    logic [7:0] sb_q[$];
    int         e = 0;
    int         next_pop_ok = 0;
    bit         frame_valid = 0;
    int         frame_p = 0;
    logic [7:0] frame_byte = 8'h00;
    bit         m_ovf = 0;
    bit         m_pop;
    bit         m_push;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            sb_q.delete();
            next_pop_ok = 0;
            frame_valid = 0;
            m_ovf = 0;
        end else begin
            e++;
            m_pop  = (mq.size() > 0) && (e >= next_pop_ok);
            m_push = doorbell && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) begin
                frame_byte  = mq.pop_front();
                frame_p     = e;
                frame_valid = 1;
                next_pop_ok = e + FRAME;
            end
            if (m_push) begin
                mq.push_back(data_in);
                sb_q.push_back(data_in);
            end
            if (doorbell && !m_push) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Monitor: per-cycle status/line checks plus a UART line decoder
    int         exp_tx;
    int         exp_busy;
    int         off;
    int         busy_cycles = 0;
    int         peak_count = 0;
    int         cyc = 0;
    int         start_cyc[$];
    bit         dec_active = 0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;

    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        exp_busy = (frame_valid && (e - frame_p) < FRAME) ? 1 : 0;
        exp_tx = 1;
        if (exp_busy != 0) begin
            off = (e - frame_p) / DIV;
            if (off == 0) exp_tx = 0;
            else if (off <= 8) exp_tx = int'(frame_byte[off-1]);
        end
        chk("tx_line", int'(tx), exp_tx);
        chk("busy", int'(busy), exp_busy);
        chk("count", int'(count), mq.size());
        chk("empty", int'(empty), (mq.size() == 0) ? 1 : 0);
        chk("full", int'(full), (mq.size() == DEPTH) ? 1 : 0);
        chk("overflow", int'(overflow), int'(m_ovf));
        if (busy) busy_cycles++;
        if (int'(count) > peak_count) peak_count = int'(count);

        if (!rst_n) begin
            dec_active = 0;
        end else if (!dec_active) begin
            if (tx == 1'b0) begin
                dec_active = 1;
                dec_cnt = 0;
                start_cyc.push_back(cyc);
            end
        end else begin
            dec_cnt++;
        end
        if (dec_active) begin
            if ((dec_cnt % DIV) == DIV / 2) begin
                if (dec_cnt / DIV == 0) begin
                    chk("start_bit", int'(tx), 0);
                end else if (dec_cnt / DIV <= 8) begin
                    dec_byte[dec_cnt/DIV-1] = tx;
                end else begin
                    chk("stop_bit", int'(tx), 1);
                    if (sb_q.size() == 0) chk("unexpected_frame", int'(dec_byte), -1);
                    else chk("rx_byte", int'(dec_byte), int'(sb_q.pop_front()));
                end
            end
            if (dec_cnt == FRAME - 1) dec_active = 0;
        end
    end

    task automatic cyc_drive(input bit db, input logic [7:0] d, input bit clr);
        @(negedge clk);
        doorbell = db;
        data_in  = d;
        ovf_clr  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, 8'($urandom), 1'b0);
    endtask

    int b0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        idle(3);

        // Single byte A5
        b0 = busy_cycles;
        cyc_drive(1'b1, 8'hA5, 1'b0);
        cyc_drive(1'b0, 8'h00, 1'b0);
        chk("single_count_after_push", int'(count), 1);
        chk("single_empty_after_push", int'(empty), 0);
        chk("single_tx_still_idle", int'(tx), 1);
        cyc_drive(1'b0, 8'h00, 1'b0);
        chk("single_tx_falls", int'(tx), 0);
        chk("single_count_after_pop", int'(count), 0);
        chk("single_busy_rises", int'(busy), 1);
        idle(FRAME + 10);
        chk("single_busy_cycles", busy_cycles - b0, FRAME);
        chk("single_empty_after", int'(empty), 1);

        // Burst 01,02,03
        b0 = busy_cycles;
        peak_count = 0;
        start_cyc.delete();
        cyc_drive(1'b1, 8'h01, 1'b0);
        cyc_drive(1'b1, 8'h02, 1'b0);
        cyc_drive(1'b1, 8'h03, 1'b0);
        idle(3 * FRAME + 10);
        chk("burst_peak_count", peak_count, 2);
        chk("burst_busy_cycles", busy_cycles - b0, 3 * FRAME);
        chk("burst_frames", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            chk("burst_gap1", start_cyc[1] - start_cyc[0], FRAME);
            chk("burst_gap2", start_cyc[2] - start_cyc[1], FRAME);
        end

        // Overflow while the first frame is on the line
        cyc_drive(1'b1, 8'h10, 1'b0);
        idle(5);
        for (int i = 0; i < 9; i++) cyc_drive(1'b1, 8'(8'h20 + i), 1'b0);
        cyc_drive(1'b0, 8'h00, 1'b0);
        chk("ovf_full", int'(full), 1);
        chk("ovf_count", int'(count), 8);
        chk("ovf_flag_set", int'(overflow), 1);
        cyc_drive(1'b0, 8'h00, 1'b1);
        cyc_drive(1'b0, 8'h00, 1'b0);
        chk("ovf_flag_cleared", int'(overflow), 0);
        idle(10 * FRAME);

        // Push on the exact STOP->START pop edge while full, then a set/clear collision
        for (int i = 0; i < 9; i++) cyc_drive(1'b1, 8'(8'h40 + i), 1'b0);
        idle(92);
        chk("simul_pre_count", int'(count), 8);
        cyc_drive(1'b1, 8'h50, 1'b0);
        cyc_drive(1'b1, 8'h60, 1'b1);
        chk("simul_count", int'(count), 8);
        chk("simul_overflow", int'(overflow), 0);
        cyc_drive(1'b0, 8'h00, 1'b0);
        chk("collision_overflow", int'(overflow), 1);
        chk("collision_count", int'(count), 8);
        cyc_drive(1'b0, 8'h00, 1'b1);
        cyc_drive(1'b0, 8'h00, 1'b0);
        chk("collision_cleared", int'(overflow), 0);
        idle(10 * FRAME);

        // Reset during data bit 3
        cyc_drive(1'b1, 8'hC3, 1'b0);
        cyc_drive(1'b1, 8'h3C, 1'b0);
        idle(44);
        chk("midrst_tx_before", int'(tx), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_count", int'(count), 0);
        chk("midrst_busy", int'(busy), 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        cyc_drive(1'b1, 8'h5A, 1'b0);
        idle(FRAME + 10);

        // Randomized traffic, dense enough to fill and overflow the FIFO
        for (int i = 0; i < 3000; i++) begin
            cyc_drive($urandom_range(0, 99) < 3, 8'($urandom),
                      $urandom_range(0, 149) == 0);
        end
        idle(9 * FRAME + 50);

        chk("scoreboard_drained", sb_q.size(), 0);
        chk("decoder_idle", int'(dec_active), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered 8N1 UART transmitter that sits directly downstream of the memory-mapped I/O port. Each one-cycle doorbell pulse pushes the byte on `data_in` into a small FIFO. A serializer drains the FIFO onto the `tx` pin at a fixed baud rate. Software can therefore write several bytes back-to-back without polling, and the status outputs are read back through the I/O port.

## Interface
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DEPTH`, 8: FIFO entries; must be a power of two, 2..256.
- `DIV` (localparam), CLK_FREQ/BAUD, integer division: clocks per bit. Must be ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  8: byte to enqueue.
- `doorbell`  in  1: one-cycle push strobe; samples `data_in` on the same edge.
- `ovf_clr`  in  1: one-cycle strobe that clears `overflow`.
- `tx`  out  1: serial output, idle high.
- `busy`  out  1: high while a frame is on the line (START, DATA or STOP state).
- `empty`  out  1: FIFO holds 0 entries.
- `full`  out  1: FIFO holds DEPTH entries.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `overflow`  out  1: sticky flag; a push was dropped because the FIFO was full.

## Operation
- Reset values, applied immediately while `rst_n`=0:
  - `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
  - FSM in IDLE; read and write pointers at 0; baud counter and bit index at 0.
- FIFO:
  - Circular buffer with pointers one bit wider than the address, so full and empty are distinguished by the MSB.
  - Push occurs when `doorbell`=1 and the FIFO is not full, or when it is full and a pop happens on the same edge.
  - A `doorbell` while full with no same-edge pop is dropped: FIFO contents unchanged, `overflow` set.
  - Simultaneous push and pop: `count` unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- `overflow` is set by a dropped push and cleared by `ovf_clr`. If both happen on the same edge, set wins.
- Serializer FSM:
  - IDLE: `tx`=1. If the FIFO is not empty, pop the head into the shift register, drive `tx`=0 and go to START.
  - START: hold for DIV clocks, then present bit 0 and go to DATA.
  - DATA: shift LSB first. Each bit is held for DIV clocks. After bit 7 has been held for DIV clocks, drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for DIV clocks. At its last clock:
    - FIFO not empty: pop the next byte, drive `tx`=0, go to START (no inter-frame gap).
    - FIFO empty: go to IDLE.
- Baud counter: counts 0..DIV-1, reloads to 0 on every bit boundary and on every entry to START.
- `tx` is driven directly from a flop, with no combinational path from the inputs.
- Status outputs are registered or derived from registered pointers only.

## Timing
- `doorbell` at edge N into an empty FIFO with the FSM in IDLE:
  - `count`=1 and `empty`=0 after edge N.
  - The pop happens at edge N+1, so `tx` falls after edge N+1 and `count` returns to 0.
- Frame length is exactly 10·DIV clocks: start bit, 8 data bits, stop bit.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Every bit period is exactly DIV clocks; there is no cumulative drift.
- `busy` rises on the same edge that `tx` first falls. It falls on the edge that enters IDLE.
- Reset asserted mid-frame: `tx` returns to 1 immediately; queued data is discarded.
- Release of `rst_n` is synchronous to `clk`; the first active edge after release behaves as IDLE.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10.
- **Single byte:** reset, one `doorbell` with `data_in`=8'hA5.
  - `tx` falls 2 edges after the doorbell.
  - Line pattern, 10 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` high for exactly 100 clocks; `empty`=1 afterwards.
- **Burst:** three consecutive-cycle doorbells, 8'h01, 8'h02, 8'h03.
  - Peak `count`=2.
  - Three contiguous frames decode to 01, 02, 03 with no idle gap; total `busy` time 300 clocks.
- **Overflow:**
  - While the first frame is sending, push 9 more bytes: `full`=1 at `count`=8, the 9th push is dropped, `overflow`=1.
  - `ovf_clr` then clears it.
  - The decoded stream contains only the 9 accepted bytes, in order.
- **Simultaneous full push and pop:**
  - With FIFO full, pulse `doorbell` on the exact STOP→START pop edge.
  - The byte is accepted, `count` stays 8, `overflow` stays 0.
- **Clear/set collision:** a dropped push and `ovf_clr` on the same edge leave `overflow`=1.
- **Reset mid-frame:**
  - Assert `rst_n`=0 during data bit 3: `tx`=1 immediately, `count`=0, `busy`=0.
  - After release, a new byte 8'h5A transmits correctly.
